// File: rtl/alu_pkg.sv
// Shared opcodes, flag positions and controller state encoding
// for the 16-bit sequenced ALU.
package alu_pkg;

    localparam logic [2:0] OP_CLR   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_PASSB = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_CMP   = 3'b111;

    localparam int FLAG_Z = 15;
    localparam int FLAG_N = 14;
    localparam int FLAG_C = 13;
    localparam int FLAG_V = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_DONE
    } state_t;

    function automatic logic [15:0] mk_status(
        input logic z,
        input logic n,
        input logic c,
        input logic v
    );
        logic [15:0] s;
        s         = '0;
        s[FLAG_Z] = z;
        s[FLAG_N] = n;
        s[FLAG_C] = c;
        s[FLAG_V] = v;
        return s;
    endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add unsigned multiplier, one step per clock.
// Ports: i_start loads operands; o_done is high during the final step's
// cycle, when o_product already shows the finished product.
module seq_mul #(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic                o_done,
    output logic [2*DATA_W-1:0] o_product
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [2*DATA_W-1:0] r_a_sh;
    logic [DATA_W-1:0]   r_b_sh;
    logic [2*DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_run;

    logic [2*DATA_W-1:0] w_addend;
    logic [2*DATA_W-1:0] w_acc_nx;

    assign w_addend = r_b_sh[0] ? r_a_sh : '0;
    assign w_acc_nx = r_acc + w_addend;

    // Product is exposed one step early so the caller can capture it
    // on the same edge that retires the last step.
    assign o_done    = r_run && (r_cnt == LAST);
    assign o_product = w_acc_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
        end else if (i_start) begin
            r_a_sh <= {{DATA_W{1'b0}}, i_a};
            r_b_sh <= i_b;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b1;
        end else if (r_run) begin
            r_acc  <= w_acc_nx;
            r_a_sh <= r_a_sh << 1;
            r_b_sh <= r_b_sh >> 1;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller: accepts one ALU op on req_*, executes it
// (multiply via seq_mul), and returns registered result/hi/low/status
// on rsp_*. busy flags any non-idle state.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] low,
    output logic [15:0]       status,
    output logic              busy
);

    localparam int SH_W = $clog2(DATA_W);

    state_t r_state;
    state_t w_state_nx;

    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_low;
    logic [15:0]       r_status;

    logic                w_accept;
    logic                w_mul_start;
    logic                w_mul_done;
    logic [2*DATA_W-1:0] w_prod;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_dif;
    logic [DATA_W-1:0] w_shl;
    logic              w_big;
    logic [DATA_W-1:0] w_res;
    logic              w_wr;
    logic              w_c;
    logic              w_v;

    assign w_accept    = (r_state == ST_IDLE) && req_valid;
    assign w_mul_start = w_accept && (req_op == OP_MUL);

    seq_mul #(.DATA_W(DATA_W)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (req_a),
        .i_b       (req_b),
        .o_done    (w_mul_done),
        .o_product (w_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nx = (req_op == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: w_state_nx = ST_DONE;
            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};
    assign w_dif = {1'b0, r_a} - {1'b0, r_b};
    // Any set bit above the shift-amount field means a full shift-out.
    assign w_big = |(r_b >> SH_W);
    assign w_shl = w_big ? '0 : (r_a << r_b[SH_W-1:0]);

    always_comb begin
        w_res = r_result;
        w_wr  = 1'b1;
        w_c   = 1'b0;
        w_v   = 1'b0;
        unique case (r_op)
            OP_CLR:   w_res = '0;
            OP_ADD: begin
                w_res = w_sum[DATA_W-1:0];
                w_c   = w_sum[DATA_W];
                w_v   = (r_a[DATA_W-1] == r_b[DATA_W-1]) &&
                        (w_sum[DATA_W-1] != r_a[DATA_W-1]);
            end
            OP_SUB, OP_CMP: begin
                w_res = w_dif[DATA_W-1:0];
                w_c   = w_dif[DATA_W];
                w_v   = (r_a[DATA_W-1] != r_b[DATA_W-1]) &&
                        (w_dif[DATA_W-1] != r_a[DATA_W-1]);
                w_wr  = (r_op != OP_CMP);
            end
            OP_AND:   w_res = r_a & r_b;
            OP_PASSB: w_res = r_b;
            OP_SHL:   w_res = w_shl;
            OP_MUL:   w_wr  = 1'b0;
            default:  w_wr  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_CLR;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_low    <= '0;
            r_status <= '0;
        end else begin
            if (w_accept) begin
                r_op <= req_op;
                r_a  <= req_a;
                r_b  <= req_b;
            end
            if (r_state == ST_EXEC) begin
                if (w_wr) begin
                    r_result <= w_res;
                end
                // For CMP, a zero difference is exactly A == B.
                r_status <= mk_status(w_res == '0, w_res[DATA_W-1],
                                      w_c, w_v);
            end
            if ((r_state == ST_MUL) && w_mul_done) begin
                r_hi     <= w_prod[2*DATA_W-1:DATA_W];
                r_low    <= w_prod[DATA_W-1:0];
                r_status <= mk_status(w_prod == '0, 1'b0, 1'b0, 1'b0);
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign result    = r_result;
    assign hi        = r_hi;
    assign low       = r_low;
    assign status    = r_status;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: vector table for the op set plus
// backpressure and mid-multiply reset sequences.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] result;
    logic [15:0] hi;
    logic [15:0] low;
    logic [15:0] status;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_ctrl #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result),
        .hi        (hi),
        .low       (low),
        .status    (status),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] st;
        logic [15:0] hi;
        logic [15:0] lo;
        int          lat;
    } vec_t;

    vec_t v[14];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op, measure edges from accept to rsp_valid, leave the
    // response pending (not yet acknowledged).
    task automatic issue(input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, output int lat,
                         output int rdy_seen);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat      = 0;
        rdy_seen = 0;
        while (!rsp_valid && lat < 40) begin
            if (req_ready || !busy) rdy_seen++;
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int rdy;
        logic [15:0] s_res;
        logic [15:0] s_st;

        v[0]  = '{3'd1, 16'h7FFF, 16'h0001, 16'h8000, 16'h5000, 16'h0000, 16'h0000, 1};
        v[1]  = '{3'd1, 16'hFFFF, 16'h0001, 16'h0000, 16'hA000, 16'h0000, 16'h0000, 1};
        v[2]  = '{3'd2, 16'h0003, 16'h0005, 16'hFFFE, 16'h6000, 16'h0000, 16'h0000, 1};
        v[3]  = '{3'd4, 16'h1111, 16'h00AA, 16'h00AA, 16'h0000, 16'h0000, 16'h0000, 1};
        v[4]  = '{3'd6, 16'h1234, 16'h0100, 16'h00AA, 16'h0000, 16'h0012, 16'h3400, 16};
        v[5]  = '{3'd7, 16'h0005, 16'h0005, 16'h00AA, 16'h8000, 16'h0012, 16'h3400, 1};
        v[6]  = '{3'd5, 16'h0001, 16'h0010, 16'h0000, 16'h8000, 16'h0012, 16'h3400, 1};
        v[7]  = '{3'd5, 16'h0003, 16'h0004, 16'h0030, 16'h0000, 16'h0012, 16'h3400, 1};
        v[8]  = '{3'd3, 16'hF0F0, 16'h8F0F, 16'h8000, 16'h4000, 16'h0012, 16'h3400, 1};
        v[9]  = '{3'd6, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000, 16'hFFFE, 16'h0001, 16};
        v[10] = '{3'd7, 16'h0001, 16'h0002, 16'h8000, 16'h6000, 16'hFFFE, 16'h0001, 1};
        v[11] = '{3'd0, 16'h1234, 16'h5678, 16'h0000, 16'h8000, 16'hFFFE, 16'h0001, 1};
        v[12] = '{3'd6, 16'h0000, 16'h1234, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16};
        v[13] = '{3'd2, 16'h8000, 16'h0001, 16'h7FFF, 16'h1000, 16'h0000, 16'h0000, 1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_hi", hi, 0);
        check("rst_low", low, 0);
        check("rst_status", status, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            issue(v[i].op, v[i].a, v[i].b, lat, rdy);
            check($sformatf("v%0d_latency", i), lat, v[i].lat);
            check($sformatf("v%0d_result", i), result, v[i].res);
            check($sformatf("v%0d_status", i), status, v[i].st);
            check($sformatf("v%0d_hi", i), hi, v[i].hi);
            check($sformatf("v%0d_low", i), low, v[i].lo);
            check($sformatf("v%0d_ready_low", i), rdy, 0);
            ack();
        end

        // Backpressure: response held while new requests knock.
        issue(3'd1, 16'h0002, 16'h0003, lat, rdy);
        check("bp_latency", lat, 1);
        s_res = result;
        s_st  = status;
        check("bp_result", s_res, 16'h0005);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = 3'd1;
            req_a     = 16'h0001;
            req_b     = 16'h0001;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_rsp_valid", i), rsp_valid, 1);
            check($sformatf("bp%0d_req_ready", i), req_ready, 0);
            check($sformatf("bp%0d_result", i), result, s_res);
            check($sformatf("bp%0d_status", i), status, s_st);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("bp_release_rsp_valid", rsp_valid, 0);
        check("bp_release_req_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("bp_accept_busy", busy, 1);
        check("bp_accept_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        check("bp_next_rsp_valid", rsp_valid, 1);
        check("bp_next_result", result, 16'h0002);
        ack();

        // Reset during the 7th multiply cycle.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd6;
        req_a     = 16'h1234;
        req_b     = 16'h0100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mr_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("mr_result", result, 0);
        check("mr_hi", hi, 0);
        check("mr_low", low, 0);
        check("mr_status", status, 0);
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_req_ready", req_ready, 1);
        check("mr_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        rdy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 if (rsp_valid) rdy++;
        end
        check("mr_no_response", rdy, 0);
        issue(3'd1, 16'h0001, 16'h0001, lat, rdy);
        check("mr_add_latency", lat, 1);
        check("mr_add_result", result, 16'h0002);
        check("mr_add_status", status, 16'h0000);
        check("mr_add_hi", hi, 16'h0000);
        check("mr_add_low", low, 16'h0000);
        ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing controller and execution wrapper for the 16-bit ALU operation set.
- Accepts one operation at a time over a valid/ready request channel.
- Executes single-cycle ops directly; runs multiply as an iterative 16-step shift-add.
- Registers result, Hi, Low and Status, then returns them on a valid/ready response channel.
- Sits between the instruction decode/issue logic and the register file.

Parameters:
DATA_W, 16, operand and result width; multiply takes DATA_W iteration cycles.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  3  opcode: 000 CLR, 001 ADD, 010 SUB, 011 AND, 100 PASSB, 101 SHL, 110 MUL, 111 CMP
req_a  in  DATA_W  operand A
req_b  in  DATA_W  operand B
rsp_valid  out  1  response outputs valid
rsp_ready  in  1  consumer accepts response
result  out  DATA_W  registered ALU result
hi  out  DATA_W  product bits [31:16]
low  out  DATA_W  product bits [15:0]
status  out  16  flags: [15] Z, [14] N, [13] C, [12] V; [11:0] always 0
busy  out  1  state is not IDLE

Behaviour:
- Reset (async, any state): state IDLE; result, hi, low, status = 0; rsp_valid = 0; req_ready = 1; busy = 0; any in-flight op is aborted with no response.
- States:
  - IDLE: req_ready = 1. On req_valid, latch op/a/b. Go to MUL if op = 110, else EXEC.
  - EXEC: one cycle. Compute, register outputs, go to DONE.
  - MUL: DATA_W cycles, counter 0..DATA_W-1. Each cycle, if b_shift[0] is set, add a_shift into the 32-bit accumulator; then a_shift <<= 1 and b_shift >>= 1. After the last step, load hi/low and go to DONE.
  - DONE: rsp_valid = 1. On rsp_ready, go to IDLE.
- Latency (request accepted at edge k):
  - Non-MUL: rsp_valid rises after edge k+1.
  - MUL: rsp_valid rises after edge k+DATA_W (k+16).
- req_ready = 0 in EXEC, MUL and DONE. Requests are never accepted back-to-back with an outstanding response.
- DONE with rsp_ready = 0: all outputs held stable indefinitely.
- Arithmetic rules (unsigned operand view for C; two's complement for N and V):
  - CLR: result = 0; status = Z only (0x8000).
  - ADD: result = A+B mod 2^16. C = bit 16 carry out. V = A, B same sign and result sign differs.
  - SUB: result = A-B mod 2^16. C = 1 when A < B unsigned (borrow). V = A, B signs differ and result sign differs from A.
  - CMP: flags computed as SUB; result, hi, low unchanged.
  - AND, PASSB: Z and N from result; C = V = 0.
  - SHL: result = A << B[3:0] when B < 16, result = 0 when B >= 16; Z and N from result; C = V = 0.
  - MUL: unsigned 32-bit product into {hi, low}; result unchanged. Z = 1 when the whole product is 0; N = C = V = 0.
- All four flags are rewritten on every op, never sticky. Z = result == 0 for result-producing ops, and for CMP Z = A == B.
- hi/low change only on MUL. result changes only on CLR, ADD, SUB, AND, PASSB, SHL.
- No combinational path from req_* to rsp_*/result.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_CLR … OP_CMP);
  - flag bit indices FLAG_Z=15, FLAG_N=14, FLAG_C=13, FLAG_V=12;
  - state encoding (IDLE, EXEC, MUL, DONE).
- One sub-module, seq_mul: iterative shift-add multiplier with start/done handshake, DATA_W-parameterised, 32-bit product output.

Test Plan:
- ADD 0x7FFF+0x0001 -> result 0x8000, status 0x5000, rsp_valid one cycle after accept-edge+1.
- ADD 0xFFFF+0x0001 -> result 0x0000, status 0xA000; then SUB 0x0003-0x0005 -> result 0xFFFE, status 0x6000.
- MUL 0x1234*0x0100 -> hi 0x0012, low 0x3400, status 0x0000, result unchanged; rsp_valid after exactly 16 cycles; req_ready = 0 throughout.
- CMP 0x0005 vs 0x0005 after result=0x00AA -> status 0x8000, result stays 0x00AA; SHL 0x0001 by 16 -> result 0x0000, status 0x8000.
- Backpressure: hold rsp_ready = 0 for 5 cycles in DONE while pulsing req_valid -> outputs stable, req_ready = 0, no request accepted; accepted on the cycle after rsp_ready.
- Assert rst at MUL cycle 7 -> same cycle: all outputs 0, req_ready = 1, busy = 0; no rsp_valid for the aborted op; the next ADD 1+1 returns 0x0002, status 0x0000.
